// File: rtl/prt_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : prt_slot_scheduler
//  Purpose  : Packet Reference Table slot sequencer. Hands free slots to the
//             receive ports, follows every slot through write, firewall
//             verdict and transmit, and feeds safe frames to the MAC tx in
//             the order they became ready.
//  Revision : 1.0  initial release
// ============================================================================
module prt_slot_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] rx_req,
    output logic [NUM_PORTS-1:0] rx_gnt,
    output logic [SLOT_W-1:0]    rx_gnt_slot,
    input  logic                 rx_done,
    input  logic [SLOT_W-1:0]    rx_done_slot,
    output logic                 rx_abort,
    output logic [SLOT_W-1:0]    rx_abort_slot,
    input  logic                 verdict_valid,
    input  logic [SLOT_W-1:0]    verdict_slot,
    input  logic                 verdict_safe,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [SLOT_W-1:0]    tx_slot,
    input  logic                 tx_done,
    output logic [SLOT_W:0]      free_count,
    output logic                 slot_avail,
    output logic                 proto_err
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Per-slot lifecycle
    localparam logic [2:0] c_ST_FREE         = 3'd0;
    localparam logic [2:0] c_ST_WRITING      = 3'd1;
    localparam logic [2:0] c_ST_WRITING_SAFE = 3'd2;
    localparam logic [2:0] c_ST_WAIT_VERDICT = 3'd3;
    localparam logic [2:0] c_ST_WAIT_TX      = 3'd4;
    localparam logic [2:0] c_ST_READING      = 3'd5;

    // Transmit sequencer
    localparam logic [0:0] c_TX_IDLE = 1'b0;
    localparam logic [0:0] c_TX_BUSY = 1'b1;

    logic [2:0]           r_state     [NUM_SLOTS];
    logic [2:0]           w_state_nxt [NUM_SLOTS];
    logic [SLOT_W-1:0]    r_q         [NUM_SLOTS];
    logic [SLOT_W-1:0]    r_q_head;
    logic [SLOT_W:0]      r_q_cnt;
    logic [0:0]           r_tx_st;
    logic [SLOT_W-1:0]    r_tx_slot;
    logic                 r_tx_start;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [SLOT_W-1:0]    r_gnt_slot;
    logic                 r_abort;
    logic [SLOT_W-1:0]    r_abort_slot;
    logic [SLOT_W:0]      r_free_count;
    logic                 r_slot_avail;
    logic                 r_err;

    logic                 w_err;
    logic                 w_push_a;
    logic                 w_push_b;
    logic                 w_abort;
    logic                 w_pop;
    logic                 w_grant;
    logic [NUM_PORTS-1:0] w_gnt_vec;
    int                   w_gnt_port;
    int                   w_best_dist;
    int                   w_dist;
    logic [SLOT_W-1:0]    w_gnt_slot;
    logic [SLOT_W:0]      w_free_nxt;
    logic [SLOT_W-1:0]    w_wr_a;
    logic [SLOT_W-1:0]    w_wr_b;
    logic [SLOT_W-1:0]    w_head_inc;

    // Queue write positions: rx_done entry goes ahead of a verdict entry in the same cycle
    assign w_wr_a     = SLOT_W'((int'(r_q_head) + int'(r_q_cnt)) % NUM_SLOTS);
    assign w_wr_b     = SLOT_W'((int'(r_q_head) + int'(r_q_cnt) + int'(w_push_a)) % NUM_SLOTS);
    assign w_head_inc = SLOT_W'((int'(r_q_head) + 1) % NUM_SLOTS);

    // Next slot states: rx_done first, then verdict on the updated state, then tx and grant
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_push_a    = 1'b0;
        w_push_b    = 1'b0;
        w_abort     = 1'b0;
        w_pop       = 1'b0;
        w_grant     = 1'b0;
        w_gnt_vec   = '0;
        w_gnt_port  = 0;
        w_best_dist = NUM_PORTS;
        w_dist      = 0;
        w_gnt_slot  = '0;
        w_free_nxt  = '0;

        if (rx_done) begin
            if (int'(rx_done_slot) >= NUM_SLOTS) begin
                w_err = 1'b1;
            end else begin
                case (r_state[rx_done_slot])
                    c_ST_WRITING:      w_state_nxt[rx_done_slot] = c_ST_WAIT_VERDICT;
                    c_ST_WRITING_SAFE: begin
                        w_state_nxt[rx_done_slot] = c_ST_WAIT_TX;
                        w_push_a                  = 1'b1;
                    end
                    default:           w_err = 1'b1;
                endcase
            end
        end

        if (verdict_valid) begin
            if (int'(verdict_slot) >= NUM_SLOTS) begin
                w_err = 1'b1;
            end else begin
                case (w_state_nxt[verdict_slot])
                    c_ST_WAIT_VERDICT: begin
                        if (verdict_safe) begin
                            w_state_nxt[verdict_slot] = c_ST_WAIT_TX;
                            w_push_b                  = 1'b1;
                        end else begin
                            w_state_nxt[verdict_slot] = c_ST_FREE;
                        end
                    end
                    c_ST_WRITING: begin
                        if (verdict_safe) begin
                            w_state_nxt[verdict_slot] = c_ST_WRITING_SAFE;
                        end else begin
                            w_state_nxt[verdict_slot] = c_ST_FREE;
                            w_abort                   = 1'b1;
                        end
                    end
                    c_ST_WRITING_SAFE: begin
                        // A repeated safe verdict changes nothing
                        if (!verdict_safe) begin
                            w_state_nxt[verdict_slot] = c_ST_FREE;
                            w_abort                   = 1'b1;
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end

        if (tx_done) begin
            if (r_tx_st == c_TX_BUSY) begin
                w_state_nxt[r_tx_slot] = c_ST_FREE;
            end else begin
                w_err = 1'b1;
            end
        end

        // Pop only from a registered IDLE so consecutive frames get an idle gap
        if (r_tx_st == c_TX_IDLE && r_q_cnt != '0 && tx_ready) begin
            w_pop                      = 1'b1;
            w_state_nxt[r_q[r_q_head]] = c_ST_READING;
        end

        // Round robin: smallest distance from the pointer wins
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rx_req[p]) begin
                w_dist = (p + NUM_PORTS - int'(r_rr_ptr)) % NUM_PORTS;
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_gnt_port  = p;
                end
            end
        end
        // Lowest-index free slot from the registered state (no same-cycle reuse)
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (r_state[s] == c_ST_FREE) begin
                w_gnt_slot = SLOT_W'(s);
            end
        end
        if (rx_req != '0 && r_free_count != '0) begin
            w_grant                 = 1'b1;
            w_state_nxt[w_gnt_slot] = c_ST_WRITING;
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_gnt_vec[p] = (p == w_gnt_port);
            end
        end

        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_state_nxt[s] == c_ST_FREE) begin
                w_free_nxt = w_free_nxt + (SLOT_W+1)'(1);
            end
        end
    end

    // Queue storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push_a) r_q[w_wr_a] <= rx_done_slot;
            if (w_push_b) r_q[w_wr_b] <= verdict_slot;
        end
    end

    // Slot states, queue pointers, tx sequencer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                r_state[s] <= c_ST_FREE;
            end
            r_q_head     <= '0;
            r_q_cnt      <= '0;
            r_tx_st      <= c_TX_IDLE;
            r_tx_slot    <= '0;
            r_tx_start   <= 1'b0;
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_gnt_slot   <= '0;
            r_abort      <= 1'b0;
            r_abort_slot <= '0;
            r_free_count <= (SLOT_W+1)'(NUM_SLOTS);
            r_slot_avail <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_q_cnt      <= (SLOT_W+1)'(int'(r_q_cnt) + int'(w_push_a) + int'(w_push_b) - int'(w_pop));
            if (w_pop) begin
                r_q_head <= w_head_inc;
            end
            r_gnt        <= w_grant ? w_gnt_vec : '0;
            r_gnt_slot   <= w_grant ? w_gnt_slot : '0;
            if (w_grant) begin
                r_rr_ptr <= PTR_W'((w_gnt_port + 1) % NUM_PORTS);
            end
            r_abort      <= w_abort;
            r_abort_slot <= w_abort ? verdict_slot : '0;
            r_tx_start   <= w_pop;
            case (r_tx_st)
                c_TX_IDLE: begin
                    if (w_pop) begin
                        r_tx_st   <= c_TX_BUSY;
                        r_tx_slot <= r_q[r_q_head];
                    end
                end
                default: begin
                    if (tx_done) begin
                        r_tx_st <= c_TX_IDLE;
                    end
                end
            endcase
            r_free_count <= w_free_nxt;
            r_slot_avail <= (w_free_nxt != '0);
            r_err        <= r_err | w_err;
        end
    end

    assign rx_gnt        = r_gnt;
    assign rx_gnt_slot   = r_gnt_slot;
    assign rx_abort      = r_abort;
    assign rx_abort_slot = r_abort_slot;
    assign tx_start      = r_tx_start;
    assign tx_slot       = r_tx_slot;
    assign free_count    = r_free_count;
    assign slot_avail    = r_slot_avail;
    assign proto_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prt_slot_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_prt_slot_scheduler
//  Purpose  : Scoreboard bench for prt_slot_scheduler. A behavioural slot
//             model predicts grants, aborts and transmit starts; a monitor
//             pops and compares them when the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prt_slot_scheduler;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int NP = 2;

    typedef enum int {M_FREE, M_WR, M_WRS, M_WV, M_WTX, M_RD} mst_t;
    typedef struct { int cyc; int a; int b; } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] rx_req;
    logic [NP-1:0] rx_gnt;
    logic [SW-1:0] rx_gnt_slot;
    logic          rx_done;
    logic [SW-1:0] rx_done_slot;
    logic          rx_abort;
    logic [SW-1:0] rx_abort_slot;
    logic          verdict_valid;
    logic [SW-1:0] verdict_slot;
    logic          verdict_safe;
    logic          tx_ready;
    logic          tx_start;
    logic [SW-1:0] tx_slot;
    logic          tx_done;
    logic [SW:0]   free_count;
    logic          slot_avail;
    logic          proto_err;

    always #5 clk = ~clk;

    prt_slot_scheduler #(.NUM_SLOTS(NS), .SLOT_W(SW), .NUM_PORTS(NP)) dut (
        .clk(clk), .rst(rst),
        .rx_req(rx_req), .rx_gnt(rx_gnt), .rx_gnt_slot(rx_gnt_slot),
        .rx_done(rx_done), .rx_done_slot(rx_done_slot),
        .rx_abort(rx_abort), .rx_abort_slot(rx_abort_slot),
        .verdict_valid(verdict_valid), .verdict_slot(verdict_slot), .verdict_safe(verdict_safe),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_slot(tx_slot), .tx_done(tx_done),
        .free_count(free_count), .slot_avail(slot_avail), .proto_err(proto_err)
    );

    // Reference model state
    int   cyc = 0;
    mst_t mst [NS];
    int   txq [$];
    bit   m_busy = 1'b0;
    int   m_txs  = 0;
    int   m_rr   = 0;
    bit   m_err  = 1'b0;
    int   m_free = NS;
    ev_t  exp_gnt [$];
    ev_t  exp_abort [$];
    ev_t  exp_tx [$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model advances on the same edge the DUT samples its inputs
    always @(posedge clk) begin : model
        int   s, busy0, q0, nfree, wslot, wport, p;
        mst_t old [NS];
        cyc++;
        if (rst) begin
            for (int i = 0; i < NS; i++) mst[i] = M_FREE;
            txq.delete();
            m_busy = 1'b0; m_rr = 0; m_err = 1'b0; m_free = NS;
        end else begin
            old   = mst;
            busy0 = m_busy;
            q0    = txq.size();
            if (rx_done) begin
                s = int'(rx_done_slot);
                if (mst[s] == M_WR) mst[s] = M_WV;
                else if (mst[s] == M_WRS) begin mst[s] = M_WTX; txq.push_back(s); end
                else m_err = 1'b1;
            end
            if (verdict_valid) begin
                s = int'(verdict_slot);
                case (mst[s])
                    M_WV:  if (verdict_safe) begin mst[s] = M_WTX; txq.push_back(s); end
                           else mst[s] = M_FREE;
                    M_WR:  if (verdict_safe) mst[s] = M_WRS;
                           else begin mst[s] = M_FREE; exp_abort.push_back('{cyc, s, 0}); end
                    M_WRS: if (!verdict_safe) begin mst[s] = M_FREE; exp_abort.push_back('{cyc, s, 0}); end
                    default: m_err = 1'b1;
                endcase
            end
            if (tx_done) begin
                if (busy0) begin mst[m_txs] = M_FREE; m_busy = 1'b0; end
                else m_err = 1'b1;
            end
            if (!busy0 && q0 > 0 && tx_ready) begin
                s = txq.pop_front();
                mst[s] = M_RD; m_busy = 1'b1; m_txs = s;
                exp_tx.push_back('{cyc, s, 0});
            end
            nfree = 0; wslot = -1;
            for (int i = NS - 1; i >= 0; i--) if (old[i] == M_FREE) begin nfree++; wslot = i; end
            if (rx_req != '0 && nfree > 0) begin
                wport = -1;
                for (int k = 0; k < NP; k++) begin
                    p = (m_rr + k) % NP;
                    if (wport < 0 && rx_req[p]) wport = p;
                end
                mst[wslot] = M_WR;
                m_rr = (wport + 1) % NP;
                exp_gnt.push_back('{cyc, 1 << wport, wslot});
            end
            m_free = 0;
            for (int i = 0; i < NS; i++) if (mst[i] == M_FREE) m_free++;
        end
    end

    // Monitor: compare registered outputs mid-cycle against the scoreboard
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            chk("free_count", int'(free_count) == m_free, int'(free_count), m_free);
            chk("slot_avail", slot_avail == (m_free != 0), int'(slot_avail), int'(m_free != 0));
            chk("proto_err", proto_err == m_err, int'(proto_err), int'(m_err));
            if (m_busy) chk("tx_slot", int'(tx_slot) == m_txs, int'(tx_slot), m_txs);

            if (rx_gnt != '0) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 1'b0, int'(rx_gnt), 0);
                else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_cycle", e.cyc == cyc, cyc, e.cyc);
                    chk("gnt_port", int'(rx_gnt) == e.a, int'(rx_gnt), e.a);
                    chk("gnt_slot", int'(rx_gnt_slot) == e.b, int'(rx_gnt_slot), e.b);
                end
            end else if (exp_gnt.size() != 0 && exp_gnt[0].cyc <= cyc) begin
                e = exp_gnt.pop_front();
                chk("gnt_missing", 1'b0, 0, e.a);
            end

            if (rx_abort) begin
                if (exp_abort.size() == 0) chk("abort_unexpected", 1'b0, int'(rx_abort_slot), -1);
                else begin
                    e = exp_abort.pop_front();
                    chk("abort_cycle", e.cyc == cyc, cyc, e.cyc);
                    chk("abort_slot", int'(rx_abort_slot) == e.a, int'(rx_abort_slot), e.a);
                end
            end else if (exp_abort.size() != 0 && exp_abort[0].cyc <= cyc) begin
                e = exp_abort.pop_front();
                chk("abort_missing", 1'b0, 0, e.a);
            end

            if (tx_start) begin
                if (exp_tx.size() == 0) chk("tx_start_unexpected", 1'b0, int'(tx_slot), -1);
                else begin
                    e = exp_tx.pop_front();
                    chk("tx_start_cycle", e.cyc == cyc, cyc, e.cyc);
                    chk("tx_start_slot", int'(tx_slot) == e.a, int'(tx_slot), e.a);
                end
            end else if (exp_tx.size() != 0 && exp_tx[0].cyc <= cyc) begin
                e = exp_tx.pop_front();
                chk("tx_start_missing", 1'b0, 0, e.a);
            end
        end
    end

    // Random well-behaved traffic with occasional protocol violations and resets
    task automatic drive_random();
        int cand [$];
        for (int p = 0; p < NP; p++) begin
            if (rx_gnt[p]) rx_req[p] = 1'b0;
            else if (!rx_req[p] && $urandom_range(0, 3) == 0) rx_req[p] = 1'b1;
        end
        rx_done = 1'b0;
        for (int s = 0; s < NS; s++) if (mst[s] == M_WR || mst[s] == M_WRS) cand.push_back(s);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            rx_done      = 1'b1;
            rx_done_slot = SW'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 59) == 0) begin
            rx_done      = 1'b1;
            rx_done_slot = SW'($urandom_range(0, NS - 1));
        end
        cand.delete();
        verdict_valid = 1'b0;
        for (int s = 0; s < NS; s++) if (mst[s] == M_WR || mst[s] == M_WRS || mst[s] == M_WV) cand.push_back(s);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            verdict_valid = 1'b1;
            verdict_slot  = SW'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 59) == 0) begin
            verdict_valid = 1'b1;
            verdict_slot  = SW'($urandom_range(0, NS - 1));
        end
        verdict_safe = ($urandom_range(0, 3) != 0);
        tx_done  = (m_busy && $urandom_range(0, 2) == 0) || (!m_busy && $urandom_range(0, 79) == 0);
        tx_ready = ($urandom_range(0, 3) != 0);
        rst      = ($urandom_range(0, 249) == 0);
    endtask

    initial begin
        rst = 1'b1; rx_req = '0; rx_done = 1'b0; rx_done_slot = '0;
        verdict_valid = 1'b0; verdict_slot = '0; verdict_safe = 1'b0;
        tx_ready = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_rx_gnt", rx_gnt == '0, int'(rx_gnt), 0);
        chk("reset_free_count", int'(free_count) == NS, int'(free_count), NS);
        chk("reset_slot_avail", slot_avail == 1'b1, int'(slot_avail), 1);
        chk("reset_tx_start", tx_start == 1'b0, int'(tx_start), 0);
        chk("reset_proto_err", proto_err == 1'b0, int'(proto_err), 0);

        // Both ports hold requests: four alternating grants, then the table is full
        rx_req = 2'b11;
        repeat (5) @(negedge clk);
        rx_req = 2'b00;
        chk("full_free_count", int'(free_count) == 0, int'(free_count), 0);
        chk("full_slot_avail", slot_avail == 1'b0, int'(slot_avail), 0);

        // Slot 0 completes and is judged safe; slot 1 is judged unsafe mid-frame
        rx_done = 1'b1; rx_done_slot = 2'd0;
        @(negedge clk);
        rx_done = 1'b0; verdict_valid = 1'b1; verdict_slot = 2'd0; verdict_safe = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        verdict_slot = 2'd1; verdict_safe = 1'b0;
        @(negedge clk);
        verdict_valid = 1'b0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        // Late rx_done on the aborted slot is a protocol error
        tx_done = 1'b0; rx_done = 1'b1; rx_done_slot = 2'd1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("proto_err_set", proto_err == 1'b1, int'(proto_err), 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_free_count", int'(free_count) == NS, int'(free_count), NS);
        chk("rst_mid_proto_err", proto_err == 1'b0, int'(proto_err), 0);

        for (int n = 0; n < 3000; n++) begin
            drive_random();
            @(negedge clk);
        end

        rst = 1'b1; rx_req = '0; rx_done = 1'b0; verdict_valid = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", (exp_gnt.size() + exp_abort.size() + exp_tx.size()) == 0,
            exp_gnt.size() + exp_abort.size() + exp_tx.size(), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prt_slot_scheduler.md
# prt_slot_scheduler

Sequences the Packet Reference Table (PRT): allocates free slots to Ethernet receive ports, tracks each slot through write, firewall verdict and transmit, and dispatches safe frames to the MAC transmitter in verdict order. It sits between the MAC rx/tx interfaces, the `prt` storage block and the firewall result path. It owns all slot bookkeeping so the datapath never picks slots itself.

## Interface
- NUM_SLOTS, 4, number of PRT slots (≤ 2**SLOT_W)
- SLOT_W, 2, slot index width
- NUM_PORTS, 2, number of receive requesters
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_req  in  NUM_PORTS  per-port request for a slot (level, held until granted)
- rx_gnt  out  NUM_PORTS  one-hot grant, single-cycle pulse
- rx_gnt_slot  out  SLOT_W  slot granted, valid with rx_gnt
- rx_done  in  1  pulse: frame fully written into rx_done_slot
- rx_done_slot  in  SLOT_W  slot finished
- rx_abort  out  1  pulse: stop receiving frame in rx_abort_slot (unsafe mid-frame)
- rx_abort_slot  out  SLOT_W  slot aborted
- verdict_valid  in  1  pulse: firewall result for verdict_slot
- verdict_slot  in  SLOT_W  slot judged
- verdict_safe  in  1  1 = transmit, 0 = invalidate
- tx_ready  in  1  MAC tx can accept a new frame
- tx_start  out  1  pulse: begin reading tx_slot from PRT
- tx_slot  out  SLOT_W  slot being transmitted, held until tx_done
- tx_done  in  1  pulse: last byte of current tx frame sent
- free_count  out  SLOT_W+1  number of FREE slots
- slot_avail  out  1  free_count != 0
- proto_err  out  1  sticky: event for a slot in an illegal state

## Operation
- Per-slot state: FREE, WRITING, WRITING_SAFE, WAIT_VERDICT, WAIT_TX, READING.
- Grant: if any rx_req and free_count != 0, grant one port round-robin (pointer starts at port 0, moves to port after winner); slot = lowest-index FREE slot; slot -> WRITING. At most one grant per cycle.
- rx_done: WRITING -> WAIT_VERDICT; WRITING_SAFE -> WAIT_TX (push tx queue).
- Verdict safe: WAIT_VERDICT -> WAIT_TX (push tx queue); WRITING -> WRITING_SAFE.
- Verdict unsafe: WAIT_VERDICT -> FREE; WRITING/WRITING_SAFE -> FREE with rx_abort pulse for that slot.
- Tx queue: FIFO of slot indices, depth NUM_SLOTS (cannot overflow), order = order of entry to WAIT_TX.
- Tx FSM IDLE: if queue non-empty and tx_ready, pop head, tx_start pulse, tx_slot = head, slot -> READING, go BUSY. BUSY: on tx_done slot -> FREE, go IDLE.
- Illegal events (rx_done on non-WRITING slot, verdict on FREE/WAIT_TX/READING slot, tx_done in IDLE, out-of-range index): no state change, proto_err set until rst.

## Timing
- Reset: all slots FREE, queue empty, tx FSM IDLE, rr pointer 0; rx_gnt=0, rx_gnt_slot=0, rx_abort=0, rx_abort_slot=0, tx_start=0, tx_slot=0, free_count=NUM_SLOTS, slot_avail=1, proto_err=0. rst mid-operation discards all in-flight frames; no abort pulses issued.
- Grant: rx_req sampled cycle N -> rx_gnt/rx_gnt_slot registered in N+1; requester must drop rx_req in N+1 or it is eligible again in N+1.
- rx_abort: verdict cycle N -> pulse in N+1.
- tx_start: conditions true cycle N -> pulse in N+1; earliest tx_start after safe verdict on WAIT_VERDICT slot is N+2 (queue push N+1, pop evaluated N+1).
- free_count/slot_avail are registered: a slot freed in cycle N is grantable from N+1; no same-cycle reuse.
- Same cycle rx_done and verdict on same slot: rx_done applied first (safe -> WAIT_TX, unsafe -> FREE, no abort).
- Same cycle tx_done and tx_start candidate: tx_start not issued until IDLE is registered (back-to-back frames separated by ≥1 idle cycle).
- Grant and free in same cycle: free_count = old − grants + frees.

## Test plan
- Reset then rx_req=2'b11 held: rx_gnt 01 slot 0, next cycle 10 slot 1, then 01 slot 2, 10 slot 3, then no grants; free_count 4→0, slot_avail=0.
- Slot 0 rx_done, verdict safe, tx_ready=1: tx_start with tx_slot=0 two cycles after verdict; tx_done -> free_count+1 next cycle.
- Slot 1 WRITING, verdict unsafe: rx_abort=1 rx_abort_slot=1 next cycle, slot FREE, later rx_done for slot 1 sets proto_err.
- Safe verdicts on slots 2 then 0 while tx busy: transmitted in order 2, 0 with tx_start gaps ≥1 cycle after each tx_done.
- Verdict safe during WRITING then rx_done: slot goes directly WAIT_TX, tx_start follows without second verdict.
- rst asserted while slot READING and queue non-empty: next cycle free_count=NUM_SLOTS, tx_start=0, proto_err=0.
